// File: rtl/memory_access_pkg.sv
// Shared constants, bus request type and lane helpers for the memory_access stage.
// Width, LSU size and bus command codes are common with the execute stage.
package memory_access_pkg;

    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_DATA_WIDTH  = 32;
    localparam int CPU_REG_WIDTH   = 32;
    localparam int CPU_REGNO_WIDTH = 5;
    localparam int CPU_LSUOP_WIDTH = 2;

    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_IDLE = 2'd0;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_BYTE = 2'd1;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_HALF = 2'd2;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_WORD = 2'd3;

    localparam logic [1:0] CPU_BUS_IDLE  = 2'd0;
    localparam logic [1:0] CPU_BUS_READ  = 2'd1;
    localparam logic [1:0] CPU_BUS_WRITE = 2'd2;

    typedef struct packed {
        logic [CPU_ADDR_WIDTH-1:0] addr;
        logic [1:0]                cmd;
        logic [CPU_DATA_WIDTH-1:0] wdata;
        logic [3:0]                be;
    } bus_req_t;

    // Big-endian lanes: byte 0 lives in bits 31:24.
    function automatic logic [3:0] lane_be(input logic [CPU_LSUOP_WIDTH-1:0] op,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            CPU_LSU_BYTE: be = 4'b1000 >> addr_lo;
            CPU_LSU_HALF: be = addr_lo[1] ? 4'b0011 : 4'b1100;
            CPU_LSU_WORD: be = 4'b1111;
            default:      be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [CPU_DATA_WIDTH-1:0] lane_wdata(input logic [CPU_LSUOP_WIDTH-1:0] op,
                                                             input logic [CPU_DATA_WIDTH-1:0] data);
        logic [CPU_DATA_WIDTH-1:0] wdata;
        wdata = data;
        case (op)
            CPU_LSU_BYTE: wdata = {4{data[7:0]}};
            CPU_LSU_HALF: wdata = {2{data[15:0]}};
            default:      wdata = data;
        endcase
        return wdata;
    endfunction

    function automatic logic misaligned_access(input logic [CPU_LSUOP_WIDTH-1:0] op,
                                               input logic [1:0] addr_lo);
        return ((op == CPU_LSU_HALF) && addr_lo[0]) ||
               ((op == CPU_LSU_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-bus interface between the memory stage (master) and the data memory (slave).
interface memory_access_if;
    import memory_access_pkg::*;

    logic [CPU_ADDR_WIDTH-1:0] addr;
    logic [1:0]                cmd;
    logic [CPU_DATA_WIDTH-1:0] wdata;
    logic [3:0]                be;
    logic                      rdy;
    logic [CPU_DATA_WIDTH-1:0] rdata;
    logic                      dvalid;

    modport master (output addr, cmd, wdata, be, input rdy, rdata, dvalid);
    modport slave  (input addr, cmd, wdata, be, output rdy, rdata, dvalid);

endinterface

// File: rtl/memory_access_load_align.sv
// Combinational load lane extraction (big-endian) with sign/zero extension.
module load_align
    import memory_access_pkg::*;
(
    input  logic [CPU_DATA_WIDTH-1:0]  rdata,
    input  logic [1:0]                 addr_lo,
    input  logic [CPU_LSUOP_WIDTH-1:0] op,
    input  logic                       ext,
    output logic [CPU_REG_WIDTH-1:0]   data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[31:24];
        lane_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (addr_lo)
            2'd0:    lane_byte = rdata[31:24];
            2'd1:    lane_byte = rdata[23:16];
            2'd2:    lane_byte = rdata[15:8];
            default: lane_byte = rdata[7:0];
        endcase
    end

    always_comb begin
        data = rdata;
        case (op)
            CPU_LSU_BYTE: data = {{24{ext & lane_byte[7]}}, lane_byte};
            CPU_LSU_HALF: data = {{16{ext & lane_half[15]}}, lane_half};
            default:      data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Ultiparc memory stage: one data-bus transaction per load/store, stalls until done.
// Optional MEMACC_ALIGN_CHECK_EN turns misaligned HALF/WORD accesses into an o_addr_err pulse.
module memory_access
    import memory_access_pkg::*;
(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_fetch_stall,
    output logic                       o_mem_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rd_no,
    input  logic [CPU_ADDR_WIDTH-1:0]  i_alu_result,
    input  logic [CPU_LSUOP_WIDTH-1:0] i_lsu_op,
    input  logic                       i_lsu_lns,
    input  logic                       i_lsu_ext,
    input  logic [CPU_DATA_WIDTH-1:0]  i_mem_data,
    memory_access_if.master            dbus,
    output logic [CPU_REGNO_WIDTH-1:0] o_rd_no,
    output logic [CPU_REG_WIDTH-1:0]   o_rd_val,
    output logic                       o_addr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]               state;
    bus_req_t                 req_q;
    logic                     is_load_q;
    logic                     misalign_q;
    logic [CPU_REG_WIDTH-1:0] load_data_q;
    logic [CPU_REG_WIDTH-1:0] align_data;
    logic                     mem_op;
    logic                     misaligned;

    assign mem_op = (i_lsu_op != CPU_LSU_IDLE);

`ifdef MEMACC_ALIGN_CHECK_EN
    assign misaligned = misaligned_access(i_lsu_op, i_alu_result[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign o_mem_stall = ((state == ST_IDLE) && mem_op) || (state == ST_CMD) || (state == ST_RESP);

    assign dbus.addr  = req_q.addr;
    assign dbus.wdata = req_q.wdata;
    assign dbus.be    = req_q.be;
    assign dbus.cmd   = (state == ST_CMD) ? req_q.cmd : CPU_BUS_IDLE;

    // The request is captured once on leaving IDLE so the bus sees a stable command until accept.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            is_load_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        is_load_q  <= i_lsu_lns;
                        misalign_q <= misaligned;
                        if (misaligned) begin
                            state <= ST_DONE;
                        end else begin
                            req_q.addr  <= {i_alu_result[CPU_ADDR_WIDTH-1:2], 2'b00};
                            req_q.cmd   <= i_lsu_lns ? CPU_BUS_READ : CPU_BUS_WRITE;
                            req_q.wdata <= lane_wdata(i_lsu_op, i_mem_data);
                            req_q.be    <= lane_be(i_lsu_op, i_alu_result[1:0]);
                            state       <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (dbus.rdy) begin
                        state <= is_load_q ? ST_RESP : ST_DONE;
                    end
                end
                ST_RESP: begin
                    if (dbus.dvalid) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!i_fetch_stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata   (dbus.rdata),
        .addr_lo (i_alu_result[1:0]),
        .op      (i_lsu_op),
        .ext     (i_lsu_ext),
        .data    (align_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            load_data_q <= '0;
        end else if ((state == ST_RESP) && dbus.dvalid) begin
            load_data_q <= align_data;
        end
    end

    // Stores and misaligned loads retire to R0 so writeback never corrupts a register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_rd_no  <= '0;
            o_rd_val <= '0;
        end else if (!(o_mem_stall || i_fetch_stall)) begin
            if (state == ST_DONE) begin
                o_rd_no  <= (is_load_q && !misalign_q) ? i_rd_no : '0;
                o_rd_val <= is_load_q ? load_data_q : i_alu_result;
            end else begin
                o_rd_no  <= i_rd_no;
                o_rd_val <= i_alu_result;
            end
        end
    end

`ifdef MEMACC_ALIGN_CHECK_EN
    logic addr_err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= (state == ST_IDLE) && mem_op && misaligned;
        end
    end

    assign o_addr_err = addr_err_q;
`else
    assign o_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reactive bus model plus a writeback scoreboard.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_fetch_stall = 1'b0;
    logic        o_mem_stall;
    logic [4:0]  i_rd_no = '0;
    logic [31:0] i_alu_result = '0;
    logic [1:0]  i_lsu_op = CPU_LSU_IDLE;
    logic        i_lsu_lns = 1'b0;
    logic        i_lsu_ext = 1'b0;
    logic [31:0] i_mem_data = '0;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;
    logic        o_addr_err;

    memory_access_if dbus();

    memory_access dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_fetch_stall (i_fetch_stall),
        .o_mem_stall   (o_mem_stall),
        .i_rd_no       (i_rd_no),
        .i_alu_result  (i_alu_result),
        .i_lsu_op      (i_lsu_op),
        .i_lsu_lns     (i_lsu_lns),
        .i_lsu_ext     (i_lsu_ext),
        .i_mem_data    (i_mem_data),
        .dbus          (dbus),
        .o_rd_no       (o_rd_no),
        .o_rd_val      (o_rd_val),
        .o_addr_err    (o_addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    wb_t wb_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] alu, input logic [1:0] op,
                                 input logic lns, input logic ext, input logic [31:0] data);
        i_rd_no      = rd;
        i_alu_result = alu;
        i_lsu_op     = op;
        i_lsu_lns    = lns;
        i_lsu_ext    = ext;
        i_mem_data   = data;
        #1;
    endtask

    task automatic checkWriteback(input string tag);
        wb_t e;
        if (wb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = wb_q.pop_front();
            checkOutput({tag, " rd_no"}, 32'(o_rd_no), 32'(e.rd));
            checkOutput({tag, " rd_val"}, o_rd_val, e.val);
        end
    endtask

    // Acts as the data memory while the stage stalls; returns at the first non-stalled negedge.
    task automatic busTransaction(input string tag, input int rdy_wait, input int dv_wait,
                                  input logic [31:0] rdata, input bit exp_bus, input logic [1:0] exp_cmd,
                                  input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                  input logic [31:0] exp_wdata, input int exp_stalls);
        int          stalls;
        int          rdy_cnt;
        int          dv_cnt;
        int          cmd_cycles;
        bit          unstable;
        logic [1:0]  f_cmd;
        logic [31:0] f_addr;
        logic [31:0] f_wdata;
        logic [3:0]  f_be;
        stalls = 0; rdy_cnt = 0; dv_cnt = -1; cmd_cycles = 0; unstable = 1'b0;
        f_cmd = '0; f_addr = '0; f_wdata = '0; f_be = '0;
        while (o_mem_stall && stalls < 64) begin
            stalls++;
            dbus.rdy    = 1'b0;
            dbus.dvalid = 1'b0;
            dbus.rdata  = 32'h5A5A5A5A;
            if (dbus.cmd != CPU_BUS_IDLE) begin
                if (cmd_cycles == 0) begin
                    f_cmd = dbus.cmd; f_addr = dbus.addr; f_be = dbus.be; f_wdata = dbus.wdata;
                end else if ({dbus.cmd, dbus.addr, dbus.be, dbus.wdata} !== {f_cmd, f_addr, f_be, f_wdata}) begin
                    unstable = 1'b1;
                end
                cmd_cycles++;
                if (rdy_cnt == rdy_wait) begin
                    dbus.rdy = 1'b1;
                    dv_cnt   = dv_wait;
                end else begin
                    rdy_cnt++;
                end
            end else if (dv_cnt >= 0) begin
                if (dv_cnt == 0) begin
                    dbus.dvalid = 1'b1;
                    dbus.rdata  = rdata;
                end
                dv_cnt--;
            end
            @(negedge clk);
        end
        dbus.rdy    = 1'b0;
        dbus.dvalid = 1'b0;
        dbus.rdata  = 32'h5A5A5A5A;
        checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
        checkOutput({tag, " stall in DONE"}, 32'(o_mem_stall), 32'd0);
        if (exp_bus) begin
            checkOutput({tag, " cmd"}, 32'(f_cmd), 32'(exp_cmd));
            checkOutput({tag, " addr"}, f_addr, exp_addr);
            checkOutput({tag, " be"}, 32'(f_be), 32'(exp_be));
            checkOutput({tag, " wdata"}, f_wdata, exp_wdata);
            checkOutput({tag, " cmd cycles"}, 32'(cmd_cycles), 32'(rdy_wait + 1));
            checkOutput({tag, " cmd stable"}, 32'(unstable), 32'd0);
        end else begin
            checkOutput({tag, " no bus cmd"}, 32'(cmd_cycles), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dbus.rdy    = 1'b0;
        dbus.dvalid = 1'b0;
        dbus.rdata  = 32'h5A5A5A5A;
        $display("[TB] memory_access bench start");

        repeat (2) @(negedge clk);
        checkOutput("reset cmd", 32'(dbus.cmd), 32'(CPU_BUS_IDLE));
        checkOutput("reset addr", dbus.addr, 32'h0);
        checkOutput("reset wdata", dbus.wdata, 32'h0);
        checkOutput("reset be", 32'(dbus.be), 32'h0);
        checkOutput("reset rd_no", 32'(o_rd_no), 32'h0);
        checkOutput("reset rd_val", o_rd_val, 32'h0);
        checkOutput("reset addr_err", 32'(o_addr_err), 32'h0);
        checkOutput("reset stall", 32'(o_mem_stall), 32'h0);
        nrst = 1'b1;
        @(negedge clk);

        applyStimulus(5'd5, 32'h12345678, CPU_LSU_IDLE, 1'b0, 1'b0, 32'h0);
        wb_q.push_back('{5'd5, 32'h12345678});
        checkOutput("nop stall", 32'(o_mem_stall), 32'h0);
        @(negedge clk);
        checkWriteback("nop");

        applyStimulus(5'd7, 32'h00001002, CPU_LSU_BYTE, 1'b0, 1'b0, 32'h000000AB);
        wb_q.push_back('{5'd0, 32'h00001002});
        busTransaction("sb", 0, 0, 32'h0, 1'b1, CPU_BUS_WRITE, 32'h00001000, 4'b0010, 32'hABABABAB, 2);
        @(negedge clk);
        checkWriteback("sb");

        applyStimulus(5'd3, 32'h00002002, CPU_LSU_HALF, 1'b1, 1'b1, 32'h0);
        wb_q.push_back('{5'd3, 32'hFFFFF00D});
        busTransaction("lh sx", 0, 0, 32'h1234F00D, 1'b1, CPU_BUS_READ, 32'h00002000, 4'b0011, 32'h0, 3);
        @(negedge clk);
        checkWriteback("lh sx");

        applyStimulus(5'd4, 32'h00002002, CPU_LSU_HALF, 1'b1, 1'b0, 32'h0);
        wb_q.push_back('{5'd4, 32'h0000F00D});
        busTransaction("lhu", 0, 0, 32'h1234F00D, 1'b1, CPU_BUS_READ, 32'h00002000, 4'b0011, 32'h0, 3);
        @(negedge clk);
        checkWriteback("lhu");

        applyStimulus(5'd9, 32'h00004000, CPU_LSU_WORD, 1'b1, 1'b0, 32'h0);
        wb_q.push_back('{5'd9, 32'hCAFEF00D});
        busTransaction("lw wait", 3, 1, 32'hCAFEF00D, 1'b1, CPU_BUS_READ, 32'h00004000, 4'b1111, 32'h0, 7);
        @(negedge clk);
        checkWriteback("lw wait");

        applyStimulus(5'd10, 32'h00005001, CPU_LSU_BYTE, 1'b1, 1'b1, 32'h0);
        i_fetch_stall = 1'b1;
        wb_q.push_back('{5'd10, 32'hFFFFFFAB});
        busTransaction("lb fstall", 0, 0, 32'h11AB2233, 1'b1, CPU_BUS_READ, 32'h00005000, 4'b0100, 32'h0, 3);
        for (int k = 0; k < 2; k++) begin
            checkOutput("fstall stall", 32'(o_mem_stall), 32'h0);
            checkOutput("fstall rd_no hold", 32'(o_rd_no), 32'd9);
            checkOutput("fstall rd_val hold", o_rd_val, 32'hCAFEF00D);
            @(negedge clk);
        end
        i_fetch_stall = 1'b0;
        #1;
        checkOutput("fstall state held", 32'(o_mem_stall), 32'h0);
        @(negedge clk);
        checkWriteback("lb fstall");

        applyStimulus(5'd2, 32'h00006002, CPU_LSU_HALF, 1'b0, 1'b0, 32'h0000BEEF);
        wb_q.push_back('{5'd0, 32'h00006002});
        busTransaction("sh", 1, 0, 32'h0, 1'b1, CPU_BUS_WRITE, 32'h00006000, 4'b0011, 32'hBEEFBEEF, 3);
        @(negedge clk);
        checkWriteback("sh");

        applyStimulus(5'd8, 32'h00007000, CPU_LSU_WORD, 1'b0, 1'b0, 32'hDEADBEEF);
        wb_q.push_back('{5'd0, 32'h00007000});
        busTransaction("sw", 0, 0, 32'h0, 1'b1, CPU_BUS_WRITE, 32'h00007000, 4'b1111, 32'hDEADBEEF, 2);
        @(negedge clk);
        checkWriteback("sw");

        applyStimulus(5'd11, 32'h00008003, CPU_LSU_BYTE, 1'b1, 1'b0, 32'h0);
        wb_q.push_back('{5'd11, 32'h000000F0});
        busTransaction("lbu lane3", 0, 0, 32'hA5A5A5F0, 1'b1, CPU_BUS_READ, 32'h00008000, 4'b0001, 32'h0, 3);
        @(negedge clk);
        checkWriteback("lbu lane3");

        applyStimulus(5'd6, 32'h00003001, CPU_LSU_WORD, 1'b1, 1'b0, 32'h0);
`ifdef MEMACC_ALIGN_CHECK_EN
        wb_q.push_back('{5'd0, 32'h000000F0});
        busTransaction("lw misalign", 0, 0, 32'h89ABCDEF, 1'b0, CPU_BUS_IDLE, 32'h0, 4'b0000, 32'h0, 1);
        checkOutput("misalign addr_err", 32'(o_addr_err), 32'h1);
        @(negedge clk);
        checkWriteback("lw misalign");
        checkOutput("misalign addr_err pulse", 32'(o_addr_err), 32'h0);
`else
        wb_q.push_back('{5'd6, 32'h89ABCDEF});
        busTransaction("lw misalign", 0, 0, 32'h89ABCDEF, 1'b1, CPU_BUS_READ, 32'h00003000, 4'b1111, 32'h0, 3);
        checkOutput("misalign addr_err", 32'(o_addr_err), 32'h0);
        @(negedge clk);
        checkWriteback("lw misalign");
`endif

        applyStimulus(5'd12, 32'h00009000, CPU_LSU_WORD, 1'b0, 1'b0, 32'h01020304);
        @(negedge clk);
        checkOutput("abort cmd before reset", 32'(dbus.cmd), 32'(CPU_BUS_WRITE));
        nrst = 1'b0;
        #1;
        checkOutput("abort cmd", 32'(dbus.cmd), 32'(CPU_BUS_IDLE));
        checkOutput("abort be", 32'(dbus.be), 32'h0);
        applyStimulus(5'd0, 32'h0, CPU_LSU_IDLE, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        applyStimulus(5'd13, 32'h00000055, CPU_LSU_IDLE, 1'b0, 1'b0, 32'h0);
        wb_q.push_back('{5'd13, 32'h00000055});
        checkOutput("post-reset stall", 32'(o_mem_stall), 32'h0);
        @(negedge clk);
        checkWriteback("post-reset nop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory pipeline stage of the Ultiparc CPU core. It sits after the execute stage and consumes its LSU command (op, load/store, extend, address from ALU result, store data). It issues one data-bus transaction per load or store, and performs byte-lane steering, byte-enables and load sign/zero extension. It stalls the core until the access completes, then presents destination register number and value to writeback.

## Interface
Parameters: none; widths come from `CPU_ADDR_WIDTH`, `CPU_DATA_WIDTH`, `CPU_REG_WIDTH`, `CPU_REGNO_WIDTH` and `CPU_LSUOP_WIDTH` in cpu_common.vh.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_fetch_stall  in  1  fetch stage stall
- o_mem_stall  out  1  this stage stall
- i_rd_no  in  REGNO  destination register from execute
- i_alu_result  in  32  ALU result; load/store address for memory ops
- i_lsu_op  in  LSUOP  `CPU_LSU_IDLE`, `CPU_LSU_BYTE`, `CPU_LSU_HALF` or `CPU_LSU_WORD`
- i_lsu_lns  in  1  1 = load, 0 = store
- i_lsu_ext  in  1  1 = sign-extend load, 0 = zero-extend
- i_mem_data  in  32  store data, right-justified
- o_dbus_addr  out  32  word-aligned bus address
- o_dbus_cmd  out  2  `CPU_BUS_IDLE`, `CPU_BUS_READ` or `CPU_BUS_WRITE`
- o_dbus_wdata  out  32  lane-replicated store data
- o_dbus_be  out  4  byte enables
- i_dbus_rdy  in  1  command accepted this cycle
- i_dbus_rdata  in  32  read data
- i_dbus_dvalid  in  1  read data valid
- o_rd_no  out  REGNO  writeback register number
- o_rd_val  out  32  writeback value
- o_addr_err  out  1  misaligned access pulse (only with MEMACC_ALIGN_CHECK_EN)

## Operation
- FSM states: IDLE, CMD, RESP, DONE. Reset state is IDLE.
- IDLE: if i_lsu_op != IDLE, latch addr, be, wdata and cmd, then go to CMD. Otherwise stay in IDLE.
- CMD: drive o_dbus_cmd. When i_dbus_rdy is high:
  - a store goes to DONE;
  - a load goes to RESP.
- RESP: when i_dbus_dvalid is high, latch the extracted/extended data and go to DONE. Data arriving in the same cycle as rdy is not legal; the bus returns data at least 1 cycle after accept.
- DONE: when i_fetch_stall is low, go to IDLE; otherwise stay in DONE.
- o_mem_stall = (IDLE && i_lsu_op != IDLE) || CMD || RESP. This is combinational.
- Execute outputs stay stable while o_mem_stall is high.
- Lane rules are big-endian; byte 0 is bits 31:24.
  - BYTE: be = 4'b1000 >> addr[1:0]; wdata = {4{data[7:0]}}.
  - HALF: be = addr[1] ? 4'b0011 : 4'b1100; wdata = {2{data[15:0]}}.
  - WORD: be = 4'b1111; wdata = data.
  - o_dbus_addr = {addr[31:2], 2'b00}.
- Load extraction selects the same lane, then extends to 32 bits per i_lsu_ext.
- Writeback registers o_rd_no and o_rd_val load when !(o_mem_stall || i_fetch_stall).
  - o_rd_val source is the load data register when the FSM is in DONE with a load. Otherwise it is i_alu_result.
  - A store writes o_rd_no = R0.
- The bus outputs hold their values from CMD entry until accept. In all other states o_dbus_cmd = IDLE.

## Timing
- Reset values: o_dbus_cmd = IDLE; o_dbus_addr, o_dbus_wdata and o_dbus_be = 0; o_rd_no = R0; o_rd_val = 0; o_addr_err = 0; o_mem_stall follows its equation.
- Non-memory op: 0 stall cycles; writeback is valid on the next edge.
- Store with rdy in the first CMD cycle: 2 stall cycles (IDLE, CMD), then DONE. Each cycle rdy stays low adds 1.
- Load: 2 stall cycles + accept wait + response wait.
- DONE with i_fetch_stall high: stall stays low, state holds, and the load data register holds.
- Reset mid-transaction aborts immediately. There is no bus cleanup; the bus resets from the same nrst.

## Configuration
- MEMACC_ALIGN_CHECK_EN defined:
  - A HALF access with addr[0] set, or a WORD access with addr[1:0] != 0, skips CMD and goes straight to DONE.
  - o_addr_err pulses for 1 cycle in DONE.
  - A misaligned load writes o_rd_no = R0.
- Not defined: the low address bits beyond the lane select are ignored, the access proceeds, and o_addr_err is tied to 0.

## Structure
- cpu_const.vh: add the `CPU_BUS_*` command codes and the `CPU_LSU_*` size codes (shared with execute).
- Local FSM state localparams.
- One sub-module, load_align: combinational lane extract and sign/zero extend from rdata, addr[1:0], op and ext.

## Test plan
- ADD result 0x12345678 to r5, no memory op -> o_mem_stall stays 0; o_rd_no = 5 and o_rd_val = 0x12345678 on the next edge.
- Store byte 0xAB at 0x1002, rdy in the first CMD cycle -> addr 0x1000, be 4'b0010, wdata 0xABABABAB; 2 stall cycles; o_rd_no = R0.
- Load half, sign-extend, at 0x2002 with rdata 0x1234F00D -> o_rd_val = 0xFFFFF00D. With ext = 0 -> 0x0000F00D.
- Load word with rdy held low 3 cycles and dvalid 2 cycles after accept -> stall lasts exactly 2+3+2 cycles; the command stays stable until accept.
- Load completes into DONE with i_fetch_stall high for 2 cycles -> state holds and o_rd_val is written only after i_fetch_stall falls.
- With MEMACC_ALIGN_CHECK_EN, load word at 0x3001 -> no bus command, o_addr_err pulse, o_rd_no = R0. Without the macro -> read at 0x3000.
